his_frame_ctrl: RTL

Frame-level sequencer for the histogram-equalization datapath. It watches the input frame timing and gates pixel accumulation into the histogram statistics stage. At each frame end it validates the pixel count, then runs a 256-bin CDF read scan and issues the equalization start flag. It then clears the histogram bins for the next frame. It sits beside the statistics and mapping stages in the top level and owns all of their frame-to-frame sequencing.

---
 rtl/his_frame_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/his_frame_ctrl.sv
// Frame-level sequencer for histogram equalisation: gates pixel accumulation,
// validates the frame size, scans the CDF, then clears the bins for the next frame.
module his_frame_ctrl #(
    parameter int IMG_TOTAL = 480000,
    parameter int BINS      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        per_img_vsync,
    input  logic        per_img_href,
    output logic        stat_en,
    output logic        hist_clr_en,
    output logic [7:0]  hist_clr_addr,
    output logic        cdf_rd_en,
    output logic [7:0]  cdf_rd_addr,
    output logic        histEQ_start_flag,
    output logic        lut_valid,
    output logic        frame_err,
    output logic        frame_skip,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARMED,
        S_ACCUM,
        S_CHECK,
        S_SCAN,
        S_DONE
    } state_e;

    localparam logic [19:0] CNT_MAX  = '1;
    localparam logic [19:0] CNT_EXP  = 20'(IMG_TOTAL);
    localparam logic [7:0]  LAST_BIN = 8'(BINS - 1);

    state_e      state_q, state_d;
    logic        vsync_q;
    logic [19:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        lut_valid_q, lut_valid_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        rise, fall;

    assign rise = per_img_vsync & ~vsync_q;
    assign fall = ~per_img_vsync & vsync_q;

    assign lut_valid = lut_valid_q;
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates so every register samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            vsync_q     <= 1'b0;
            pix_cnt_q   <= '0;
            addr_q      <= '0;
            lut_valid_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= per_img_vsync;
            pix_cnt_q   <= pix_cnt_d;
            addr_q      <= addr_d;
            lut_valid_q <= lut_valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d           = state_q;
        pix_cnt_d         = pix_cnt_q;
        addr_d            = '0;
        lut_valid_d       = lut_valid_q;
        frame_cnt_d       = frame_cnt_q;
        stat_en           = 1'b0;
        hist_clr_en       = 1'b0;
        cdf_rd_en         = 1'b0;
        histEQ_start_flag = 1'b0;
        frame_err         = 1'b0;
        frame_skip        = 1'b0;
        busy              = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (enable) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                hist_clr_en = 1'b1;
                frame_skip  = rise;
                if (addr_q == LAST_BIN) state_d = enable ? S_ARMED : S_IDLE;
                else                    addr_d  = addr_q + 8'd1;
            end
            S_ARMED: begin
                busy = 1'b0;
                if (rise) begin
                    // A pixel coincident with the vsync rise belongs to this frame.
                    stat_en   = per_img_href;
                    pix_cnt_d = {19'd0, per_img_href};
                    state_d   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                stat_en = per_img_vsync & per_img_href;
                if (stat_en && pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + 20'd1;
                if (fall) state_d = S_CHECK;
            end
            S_CHECK: begin
                frame_skip = rise;
                if (pix_cnt_q == CNT_EXP) begin
                    state_d = S_SCAN;
                end else begin
                    frame_err = 1'b1;
                    state_d   = S_CLEAR;
                end
            end
            S_SCAN: begin
                cdf_rd_en  = 1'b1;
                frame_skip = rise;
                if (addr_q == LAST_BIN) state_d = S_DONE;
                else                    addr_d  = addr_q + 8'd1;
            end
            S_DONE: begin
                histEQ_start_flag = 1'b1;
                frame_skip        = rise;
                lut_valid_d       = 1'b1;
                frame_cnt_d       = frame_cnt_q + 16'd1;
                state_d           = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase

        hist_clr_addr = hist_clr_en ? addr_q : 8'd0;
        cdf_rd_addr   = cdf_rd_en ? addr_q : 8'd0;
    end

endmodule
